// File: rtl/cmp_pkg.sv
// Shared types for the comparator result tracker.
// Build option CMP_ERR_FLAG_EN: strict one-hot decode (else alb > agb > aeb).
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_UNK = 2'b00,
    CMP_EQ  = 2'b01,
    CMP_GT  = 2'b10,
    CMP_LT  = 2'b11
  } cmp_state_t;

  typedef struct packed {
    logic       vld;
    cmp_state_t cls;
  } cmp_dec_t;

  function automatic cmp_dec_t cmp_decode(
    input logic aeb,
    input logic agb,
    input logic alb
  );
    cmp_dec_t d;
    d.vld = 1'b0;
    d.cls = CMP_UNK;
`ifdef CMP_ERR_FLAG_EN
    unique case ({alb, agb, aeb})
      3'b100: begin d.vld = 1'b1; d.cls = CMP_LT; end
      3'b010: begin d.vld = 1'b1; d.cls = CMP_GT; end
      3'b001: begin d.vld = 1'b1; d.cls = CMP_EQ; end
      default: ;
    endcase
`else
    priority case (1'b1)
      alb: begin d.vld = 1'b1; d.cls = CMP_LT; end
      agb: begin d.vld = 1'b1; d.cls = CMP_GT; end
      aeb: begin d.vld = 1'b1; d.cls = CMP_EQ; end
      default: ;
    endcase
`endif
    return d;
  endfunction

endpackage

// File: rtl/cmp_result_tracker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Used once per comparison class by cmp_result_tracker.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = '0;
    else if (inc && (q_q != {W{1'b1}}))
      q_d = q_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q_q <= '0;
    else
      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/cmp_result_tracker.sv
// Debounces comparator flags into a stable EQ/GT/LT relation with counts.
// Build option CMP_ERR_FLAG_EN: reject non-one-hot samples, sticky err port.
module cmp_result_tracker
  import cmp_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int HOLD  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       aeb,
  input  logic                       agb,
  input  logic                       alb,
  input  logic                       clr,
  output logic [1:0]                 state,
  output logic                       state_chg,
  output logic [$clog2(HOLD+1)-1:0]  run_len,
  output logic [CNT_W-1:0]           eq_cnt,
  output logic [CNT_W-1:0]           gt_cnt,
`ifdef CMP_ERR_FLAG_EN
  output logic                       err,
`endif
  output logic [CNT_W-1:0]           lt_cnt
);

  localparam int RW = $clog2(HOLD + 1);
  localparam logic [RW-1:0] HOLD_L = RW'(HOLD);
  localparam logic [RW-1:0] ONE_L  = RW'(1);

  cmp_dec_t   dec;
  logic       acc;
  cmp_state_t state_q, state_d;
  cmp_state_t cand_q, cand_d;
  logic [RW-1:0] run_q, run_d;
  logic       chg_q, chg_d;
`ifdef CMP_ERR_FLAG_EN
  logic       bad;
  logic       err_q, err_d;
`endif

  always_comb begin
    dec = cmp_decode(aeb, agb, alb);
    acc = in_valid & ~clr & dec.vld;
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    run_d   = run_q;
    chg_d   = 1'b0;
`ifdef CMP_ERR_FLAG_EN
    bad     = in_valid & ~clr & ~dec.vld;
    err_d   = err_q;
`endif
    if (clr) begin
      state_d = CMP_UNK;
      cand_d  = CMP_UNK;
      run_d   = '0;
`ifdef CMP_ERR_FLAG_EN
      err_d   = 1'b0;
`endif
    end else if (acc) begin
      if (dec.cls == cand_q) begin
        if (run_q != HOLD_L)
          run_d = run_q + ONE_L;
      end else begin
        cand_d = dec.cls;
        run_d  = ONE_L;
      end
      // Commit only once the run reaches HOLD with a new relation
      if ((run_d == HOLD_L) && (cand_d != state_q)) begin
        state_d = cand_d;
        chg_d   = 1'b1;
      end
    end
`ifdef CMP_ERR_FLAG_EN
    else if (bad) begin
      cand_d = CMP_UNK;
      run_d  = '0;
      err_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CMP_UNK;
      cand_q  <= CMP_UNK;
      run_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      run_q   <= run_d;
      chg_q   <= chg_d;
    end
  end

`ifdef CMP_ERR_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else
      err_q <= err_d;
  end

  assign err = err_q;
`endif

  sat_counter #(.W(CNT_W)) u_eq (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (acc && (dec.cls == CMP_EQ)),
    .q   (eq_cnt)
  );

  sat_counter #(.W(CNT_W)) u_gt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (acc && (dec.cls == CMP_GT)),
    .q   (gt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_lt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (acc && (dec.cls == CMP_LT)),
    .q   (lt_cnt)
  );

  assign state     = state_q;
  assign state_chg = chg_q;
  assign run_len   = run_q;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Bench for cmp_result_tracker: HOLD=3/CNT_W=8 and HOLD=1/CNT_W=2 instances.
// Honours CMP_ERR_FLAG_EN when defined.
module tb_cmp_result_tracker;

  logic clk = 1'b0;
  logic rst, in_valid, aeb, agb, alb, clr;

  logic [1:0] a_state;
  logic       a_chg;
  logic [1:0] a_run;
  logic [7:0] a_eq, a_gt, a_lt;
  logic [1:0] b_state;
  logic       b_chg;
  logic [0:0] b_run;
  logic [1:0] b_eq, b_gt, b_lt;
`ifdef CMP_ERR_FLAG_EN
  logic a_err, b_err;
`endif

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cmp_result_tracker #(.CNT_W(8), .HOLD(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .aeb(aeb), .agb(agb), .alb(alb), .clr(clr),
    .state(a_state), .state_chg(a_chg), .run_len(a_run),
    .eq_cnt(a_eq), .gt_cnt(a_gt),
`ifdef CMP_ERR_FLAG_EN
    .err(a_err),
`endif
    .lt_cnt(a_lt)
  );

  cmp_result_tracker #(.CNT_W(2), .HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .aeb(aeb), .agb(agb), .alb(alb), .clr(clr),
    .state(b_state), .state_chg(b_chg), .run_len(b_run),
    .eq_cnt(b_eq), .gt_cnt(b_gt),
`ifdef CMP_ERR_FLAG_EN
    .err(b_err),
`endif
    .lt_cnt(b_lt)
  );

  // Model: list of accepted classes since last clr/rst (0 = rejected sample)
  int hist[$];
  int m_chg_a, m_chg_b, m_err;

  function automatic int m_state(int hold);
    int st = 0, run = 0, prev = -1;
    foreach (hist[i]) begin
      if (hist[i] == 0) run = 0;
      else if (hist[i] == prev) run++;
      else run = 1;
      prev = hist[i];
      if (hist[i] != 0 && run >= hold) st = hist[i];
    end
    return st;
  endfunction

  function automatic int m_run(int hold);
    int run = 0;
    int last;
    if (hist.size() == 0) return 0;
    last = hist[hist.size()-1];
    if (last == 0) return 0;
    for (int i = hist.size()-1; i >= 0; i--) begin
      if (hist[i] != last) break;
      run++;
    end
    return (run > hold) ? hold : run;
  endfunction

  function automatic int m_cnt(int c, int mx);
    int n = 0;
    foreach (hist[i]) if (hist[i] == c) n++;
    return (n > mx) ? mx : n;
  endfunction

  task automatic m_clear();
    hist.delete();
    m_chg_a = 0;
    m_chg_b = 0;
    m_err = 0;
  endtask

  task automatic m_update(input logic v, e, g, l, c);
    int sa = m_state(3);
    int sb = m_state(1);
    if (c) begin
      m_clear();
      return;
    end
    if (v) begin
`ifdef CMP_ERR_FLAG_EN
      if ({l, g, e} == 3'b100) hist.push_back(3);
      else if ({l, g, e} == 3'b010) hist.push_back(2);
      else if ({l, g, e} == 3'b001) hist.push_back(1);
      else begin
        hist.push_back(0);
        m_err = 1;
      end
`else
      if (l) hist.push_back(3);
      else if (g) hist.push_back(2);
      else if (e) hist.push_back(1);
`endif
    end
    m_chg_a = int'(m_state(3) != sa);
    m_chg_b = int'(m_state(1) != sb);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("A.state", int'(a_state), m_state(3));
      chk("A.chg", int'(a_chg), m_chg_a);
      chk("A.run", int'(a_run), m_run(3));
      chk("A.eq", int'(a_eq), m_cnt(1, 255));
      chk("A.gt", int'(a_gt), m_cnt(2, 255));
      chk("A.lt", int'(a_lt), m_cnt(3, 255));
      chk("B.state", int'(b_state), m_state(1));
      chk("B.chg", int'(b_chg), m_chg_b);
      chk("B.run", int'(b_run), m_run(1));
      chk("B.eq", int'(b_eq), m_cnt(1, 3));
      chk("B.gt", int'(b_gt), m_cnt(2, 3));
      chk("B.lt", int'(b_lt), m_cnt(3, 3));
`ifdef CMP_ERR_FLAG_EN
      chk("A.err", int'(a_err), m_err);
      chk("B.err", int'(b_err), m_err);
`endif
    end
  end

  task automatic step(input logic v, e, g, l, c);
    in_valid = v; aeb = e; agb = g; alb = l; clr = c;
    @(posedge clk);
    m_update(v, e, g, l, c);
    @(negedge clk);
  endtask

  task automatic gt();   step(1, 0, 1, 0, 0); endtask
  task automatic lt();   step(1, 0, 0, 1, 0); endtask
  task automatic eq();   step(1, 1, 0, 0, 0); endtask
  task automatic idle(); step(0, 0, 0, 0, 0); endtask
  task automatic clear(); step(0, 0, 0, 0, 1); endtask

  initial begin
    rst = 1'b1;
    {in_valid, aeb, agb, alb, clr} = '0;
    m_clear();
    repeat (2) @(negedge clk);
    chk("rst.A.state", int'(a_state), 0);
    chk("rst.A.gt", int'(a_gt), 0);
    chk("rst.B.run", int'(b_run), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    gt(); gt();
    chk("pre_rst.A.gt", int'(a_gt), 2);
    chk("pre_rst.A.run", int'(a_run), 2);
    #2 rst = 1'b1;
    #1;
    chk("async.A.gt", int'(a_gt), 0);
    chk("async.A.run", int'(a_run), 0);
    chk("async.B.state", int'(b_state), 0);
    chk("async.B.gt", int'(b_gt), 0);
    m_clear();
    @(negedge clk);
    rst = 1'b0;

    gt();
    chk("s1.A.state1", int'(a_state), 0);
    chk("s1.B.state", int'(b_state), 2);
    chk("s1.B.chg", int'(b_chg), 1);
    gt(); gt();
    chk("s1.A.state", int'(a_state), 2);
    chk("s1.A.chg", int'(a_chg), 1);
    chk("s1.A.gt", int'(a_gt), 3);
    idle();
    chk("s1.A.chg_off", int'(a_chg), 0);

    clear();
    gt(); gt(); lt(); gt(); gt();
    chk("s2.A.state", int'(a_state), 0);
    chk("s2.A.run", int'(a_run), 2);
    chk("s2.A.gt", int'(a_gt), 4);
    chk("s2.A.lt", int'(a_lt), 1);
    chk("s2.B.gt", int'(b_gt), 3);

    clear();
    eq(); eq();
    repeat (5) idle();
    chk("s3.A.state_pre", int'(a_state), 0);
    chk("s3.A.run_pre", int'(a_run), 2);
    eq();
    chk("s3.A.state", int'(a_state), 1);
    chk("s3.A.chg", int'(a_chg), 1);

    clear();
    repeat (5) eq();
    chk("s4.B.eq5", int'(b_eq), 3);
    chk("s4.A.eq5", int'(a_eq), 5);
    eq();
    chk("s4.B.eq6", int'(b_eq), 3);

    clear();
    lt(); lt(); lt();
    chk("s5.A.lt_state", int'(a_state), 3);
    step(1, 0, 1, 0, 1);
    chk("s5.A.state", int'(a_state), 0);
    chk("s5.A.gt", int'(a_gt), 0);
    chk("s5.A.run", int'(a_run), 0);
    chk("s5.A.chg", int'(a_chg), 0);

    eq();
    step(1, 0, 1, 1, 0);
`ifdef CMP_ERR_FLAG_EN
    chk("s6.A.err", int'(a_err), 1);
    chk("s6.A.run", int'(a_run), 0);
    chk("s6.A.lt", int'(a_lt), 0);
    idle();
    chk("s6.A.err_sticky", int'(a_err), 1);
`else
    chk("s6.A.lt", int'(a_lt), 1);
    chk("s6.A.run", int'(a_run), 1);
    step(1, 1, 1, 0, 0);
    chk("prio.A.gt", int'(a_gt), 1);
    step(1, 0, 0, 0, 0);
    chk("zero.A.run", int'(a_run), 1);
    chk("zero.A.eq", int'(a_eq), 1);
`endif
    lt(); gt();
    chk("h1.B.state", int'(b_state), 2);
    chk("h1.B.chg", int'(b_chg), 1);
    idle();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
